// File: rtl/nfc_command_receiver_pkg.sv
// Shared types and constants for the NAND flash controller command receiver.
// Holds the command record layout, FSM encoding and status word layout.
package nfc_command_receiver_pkg;

  localparam int unsigned OpcodeWidth  = 6;
  localparam int unsigned TargetWidth  = 5;
  localparam int unsigned AddressWidth = 32;
  localparam int unsigned LengthWidth  = 16;
  localparam int unsigned TimerWidth   = 16;
  localparam int unsigned StatusWidth  = 24;

  typedef struct packed {
    logic [OpcodeWidth-1:0]  opcode;
    logic [TargetWidth-1:0]  target;
    logic [AddressWidth-1:0] address;
    logic [LengthWidth-1:0]  length;
  } cmd_t;

  localparam int unsigned CmdWidth = $bits(cmd_t);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRb,
    StIssue,
    StBusy,
    StReport
  } state_e;

  localparam logic [7:0] StatusOk        = 8'h00;
  localparam logic [7:0] StatusExecErr   = 8'h01;
  localparam logic [7:0] StatusBadTarget = 8'h02;
  localparam logic [7:0] StatusRbTimeout = 8'h03;

  localparam int unsigned StatusOpcodeLsb = 18;
  localparam int unsigned StatusTargetLsb = 13;
  localparam int unsigned StatusCodeLsb   = 0;

  // Bits [12:8] of the status word are reserved and always zero.
  function automatic logic [StatusWidth-1:0] pack_status(logic [OpcodeWidth-1:0] opcode,
                                                         logic [TargetWidth-1:0] target,
                                                         logic [7:0]             code);
    logic [StatusWidth-1:0] status;
    status = '0;
    status[StatusOpcodeLsb +: OpcodeWidth] = opcode;
    status[StatusTargetLsb +: TargetWidth] = target;
    status[StatusCodeLsb +: 8]             = code;
    return status;
  endfunction

endpackage

// File: rtl/nfc_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
// The head entry is presented combinationally whenever the FIFO is non-empty.
module nfc_cmd_fifo #(
  parameter int unsigned Depth      = 4,
  parameter int unsigned Width      = 59,
  localparam int unsigned PtrWidth   = $clog2(Depth),
  localparam int unsigned CountWidth = $clog2(Depth + 1)
) (
  input  logic                  iSystemClock,
  input  logic                  iReset,
  input  logic                  iPush,
  input  logic [Width-1:0]      iData,
  input  logic                  iPop,
  output logic [Width-1:0]      oHead,
  output logic [CountWidth-1:0] oCount
);

  logic [Width-1:0]      mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q;
  logic [PtrWidth-1:0]   rd_ptr_q;
  logic [CountWidth-1:0] count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = iPush && (count_q != CountWidth'(Depth));
  assign do_pop  = iPop && (count_q != '0);

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CountWidth'(1);
        2'b01:   count_q <= count_q - CountWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge iSystemClock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= iData;
    end
  end

  assign oHead  = mem_q[rd_ptr_q];
  assign oCount = count_q;

endmodule

// File: rtl/nfc_command_receiver.sv
// Command-side responder: queues commands, waits for the target way's R/B line,
// hands each command to the way executor and reports a 24-bit status word.
module nfc_command_receiver
  import nfc_command_receiver_pkg::*;
#(
  parameter int unsigned NumberOfWays  = 2,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [5:0]              iOpcode,
  input  logic [4:0]              iTargetID,
  input  logic [4:0]              iSourceID,
  input  logic [31:0]             iAddress,
  input  logic [15:0]             iLength,
  input  logic                    iCMDValid,
  output logic                    oCMDReady,
  output logic [23:0]             oStatus,
  output logic                    oStatusValid,
  input  logic [NumberOfWays-1:0] iReadyBusy,
  output logic [5:0]              oExecOpcode,
  output logic [4:0]              oExecTargetID,
  output logic [31:0]             oExecAddress,
  output logic [15:0]             oExecLength,
  output logic                    oExecValid,
  input  logic                    iExecReady,
  input  logic                    iExecDone,
  input  logic                    iExecError
);

  localparam int unsigned CountWidth = $clog2(FifoDepth + 1);

  cmd_t                    cmd_in;
  cmd_t                    cmd_head;
  logic [CountWidth-1:0]   fifo_count;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_nonempty;

  logic [NumberOfWays-1:0] rb_meta_q;
  logic [NumberOfWays-1:0] rb_sync_q;
  logic [31:0]             rb_ways;
  logic                    head_target_valid;
  logic                    head_way_ready;
  logic                    timeout_hit;

  state_e                  state_q, state_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;
  logic [StatusWidth-1:0]  status_q, status_d;

  // The requester ID is accepted on the bus but never stored.
  logic unused_source;
  assign unused_source = ^iSourceID;

  assign cmd_in = '{opcode: iOpcode, target: iTargetID, address: iAddress, length: iLength};

  assign oCMDReady     = (fifo_count != CountWidth'(FifoDepth));
  assign fifo_push     = iCMDValid && oCMDReady;
  assign fifo_nonempty = (fifo_count != '0);

  nfc_cmd_fifo #(
    .Depth (FifoDepth),
    .Width (CmdWidth)
  ) u_cmd_fifo (
    .iSystemClock (iSystemClock),
    .iReset       (iReset),
    .iPush        (fifo_push),
    .iData        (cmd_in),
    .iPop         (fifo_pop),
    .oHead        (cmd_head),
    .oCount       (fifo_count)
  );

  // R/B pins are asynchronous to the system clock.
  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      rb_meta_q <= '0;
      rb_sync_q <= '0;
    end else begin
      rb_meta_q <= iReadyBusy;
      rb_sync_q <= rb_meta_q;
    end
  end

  // Zero-extend to 32 ways so any 5-bit target indexes safely.
  always_comb begin
    rb_ways                   = '0;
    rb_ways[NumberOfWays-1:0] = rb_sync_q;
  end

  assign head_target_valid = ({1'b0, cmd_head.target} < 6'(NumberOfWays));
  assign head_way_ready    = rb_ways[cmd_head.target];
  assign timeout_hit       = (TimeoutCycles != 0) &&
                             (timer_q == TimerWidth'(TimeoutCycles - 1));

  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    status_d = status_q;
    unique case (state_q)
      StIdle: begin
        if (fifo_nonempty) begin
          if (!head_target_valid) begin
            state_d  = StReport;
            status_d = pack_status(cmd_head.opcode, cmd_head.target, StatusBadTarget);
          end else begin
            state_d = StWaitRb;
            timer_d = '0;
          end
        end
      end
      StWaitRb: begin
        if (head_way_ready) begin
          state_d = StIssue;
        end else if (timeout_hit) begin
          state_d  = StReport;
          status_d = pack_status(cmd_head.opcode, cmd_head.target, StatusRbTimeout);
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end
      StIssue: begin
        if (iExecReady) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (iExecDone) begin
          state_d  = StReport;
          status_d = pack_status(cmd_head.opcode, cmd_head.target,
                                 iExecError ? StatusExecErr : StatusOk);
        end
      end
      StReport: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The command stays at the FIFO head until its status has been reported.
  always_comb begin
    oExecValid    = 1'b0;
    oExecOpcode   = '0;
    oExecTargetID = '0;
    oExecAddress  = '0;
    oExecLength   = '0;
    oStatusValid  = 1'b0;
    fifo_pop      = 1'b0;
    unique case (state_q)
      StIssue: begin
        oExecValid    = 1'b1;
        oExecOpcode   = cmd_head.opcode;
        oExecTargetID = cmd_head.target;
        oExecAddress  = cmd_head.address;
        oExecLength   = cmd_head.length;
      end
      StReport: begin
        oStatusValid = 1'b1;
        fifo_pop     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign oStatus = status_q;

endmodule

// File: tb/tb_nfc_command_receiver.sv
// Self-checking bench for nfc_command_receiver: directed table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_nfc_command_receiver;

  localparam int unsigned NumWays = 2;
  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 20;

  logic        clk = 1'b0;
  logic        iReset;
  logic [5:0]  iOpcode;
  logic [4:0]  iTargetID;
  logic [4:0]  iSourceID;
  logic [31:0] iAddress;
  logic [15:0] iLength;
  logic        iCMDValid;
  logic        oCMDReady;
  logic [23:0] oStatus;
  logic        oStatusValid;
  logic [1:0]  iReadyBusy;
  logic [5:0]  oExecOpcode;
  logic [4:0]  oExecTargetID;
  logic [31:0] oExecAddress;
  logic [15:0] oExecLength;
  logic        oExecValid;
  logic        iExecReady;
  logic        iExecDone;
  logic        iExecError;

  always #5 clk = ~clk;

  nfc_command_receiver #(
    .NumberOfWays  (NumWays),
    .FifoDepth     (Depth),
    .TimeoutCycles (Timeout)
  ) dut (
    .iSystemClock  (clk),
    .iReset        (iReset),
    .iOpcode       (iOpcode),
    .iTargetID     (iTargetID),
    .iSourceID     (iSourceID),
    .iAddress      (iAddress),
    .iLength       (iLength),
    .iCMDValid     (iCMDValid),
    .oCMDReady     (oCMDReady),
    .oStatus       (oStatus),
    .oStatusValid  (oStatusValid),
    .iReadyBusy    (iReadyBusy),
    .oExecOpcode   (oExecOpcode),
    .oExecTargetID (oExecTargetID),
    .oExecAddress  (oExecAddress),
    .oExecLength   (oExecLength),
    .oExecValid    (oExecValid),
    .iExecReady    (iExecReady),
    .iExecDone     (iExecDone),
    .iExecError    (iExecError)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  tgt;
    logic [31:0] addr;
    logic [15:0] len;
    bit          stuck;
  } cmd_rec_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  tgt;
    logic [31:0] addr;
    logic [15:0] len;
    bit          err;
    logic [23:0] exp;
  } vec_t;

  // Reference model: commands in push order, executor error flags in issue order.
  cmd_rec_t exp_mem [512];
  int       exp_wr = 0, exp_rd = 0;
  bit       err_mem [512];
  int       err_wr = 0, err_rd = 0;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, push_cyc = 0, last_strobe_cyc = 0;
  int strobe_cnt = 0, exec_valid_cnt = 0;
  bit hs_seen = 1'b0, prev_sv = 1'b0;

  int ready_mode = 1, err_mode = 0, exec_lat = 2, stray_cnt = 0;
  bit lat_rand = 1'b0;
  int ex_cd = -1, ex_stray = 0;
  bit ex_err = 1'b0;

  vec_t vecs [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_status(cmd_rec_t c, bit err);
    int code;
    if (c.tgt >= NumWays) code = 2;
    else if (c.stuck)     code = 3;
    else                  code = err ? 1 : 0;
    return 24'(c.op * 262144 + c.tgt * 8192 + code);
  endfunction

  // Scoreboard, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    cmd_rec_t c;
    bit       e;
    hs_seen = oExecValid && iExecReady;
    if (!iReset) begin
      exp_rd  = exp_wr;
      err_rd  = err_wr;
      prev_sv = 1'b0;
    end else begin
      if (oExecValid) exec_valid_cnt++;
      if (hs_seen) begin
        if (exp_rd == exp_wr) begin
          n_checks++; n_fail++;
          $display("FAIL exec_unexpected: got request op 0x%0h, expected none", oExecOpcode);
        end else begin
          c = exp_mem[exp_rd % 512];
          check("exec_legal", 64'((c.tgt < NumWays) && !c.stuck), 64'd1);
          check("exec_fields", 64'({oExecOpcode, oExecTargetID, oExecAddress, oExecLength}),
                64'({c.op, c.tgt, c.addr, c.len}));
        end
      end
      if (oStatusValid) begin
        strobe_cnt++;
        last_strobe_cyc = cyc;
        check("strobe_width", 64'(prev_sv), 64'd0);
        if (exp_rd == exp_wr) begin
          n_checks++; n_fail++;
          $display("FAIL status_unexpected: got 0x%0h, expected no strobe", oStatus);
        end else begin
          c = exp_mem[exp_rd % 512];
          e = 1'b0;
          if ((c.tgt < NumWays) && !c.stuck) begin
            if (err_rd == err_wr) begin
              n_checks++; n_fail++;
              $display("FAIL status_no_exec: got 0x%0h, expected executor handshake", oStatus);
            end else begin
              e = err_mem[err_rd % 512];
              err_rd++;
            end
          end
          check("status_word", 64'(oStatus), 64'(exp_status(c, e)));
          exp_rd++;
        end
      end
      prev_sv = oStatusValid;
    end
  end

  // Executor model: accepts per ready_mode, completes exec_lat cycles later.
  always begin : executor
    @(posedge clk); #1;
    iExecDone  = 1'b0;
    iExecError = 1'b0;
    if (!iReset) begin
      ex_cd = -1;
    end else begin
      if (hs_seen) begin
        ex_cd  = lat_rand ? int'($urandom_range(0, 6)) : exec_lat;
        ex_err = (err_mode == 2) ? ($urandom_range(0, 1) == 1) : (err_mode == 1);
        err_mem[err_wr % 512] = ex_err;
        err_wr++;
      end else if (ex_cd > 0) begin
        ex_cd--;
      end else if (ex_cd == 0) begin
        iExecDone  = 1'b1;
        iExecError = ex_err;
        ex_cd      = -1;
      end
      if (ex_stray != stray_cnt) begin
        iExecDone = 1'b1;
        ex_stray  = stray_cnt;
      end
    end
    iExecReady = (ready_mode == 1) || ((ready_mode == 2) && ($urandom_range(0, 1) == 1));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic [5:0] op, input logic [4:0] tgt,
                          input logic [31:0] addr, input logic [15:0] len);
    bit acc;
    bit ok;
    bit stuck;
    iOpcode   = op;
    iTargetID = tgt;
    iAddress  = addr;
    iLength   = len;
    iSourceID = 5'($urandom);
    iCMDValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      acc = oCMDReady;
      tick();
      if (acc) begin
        stuck = (tgt < NumWays) && !iReadyBusy[tgt[0]];
        exp_mem[exp_wr % 512] = '{op, tgt, addr, len, stuck};
        exp_wr++;
        push_cyc = cyc;
        ok = 1'b1;
      end
    end
    iCMDValid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: got oCMDReady low for 300 cycles, expected acceptance");
    end
  endtask

  task automatic drain(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (exp_rd == exp_wr);
    end
    check(name, 64'(ok), 64'd1);
  endtask

  initial begin
    int sc;
    int ev;
    int pc;
    vecs[0] = '{6'h05, 5'd0,  32'h0000_1234, 16'd512, 1'b0, 24'h140000};
    vecs[1] = '{6'h3F, 5'd1,  32'hFFFF_0000, 16'd1,   1'b1, 24'hFC2001};
    vecs[2] = '{6'h01, 5'd3,  32'h0000_0010, 16'd4,   1'b0, 24'h046002};
    vecs[3] = '{6'h2A, 5'd1,  32'hDEAD_BEEF, 16'd0,   1'b0, 24'hA82000};
    vecs[4] = '{6'h00, 5'd31, 32'h1357_9BDF, 16'hFFFF, 1'b0, 24'h03E002};
    vecs[5] = '{6'h12, 5'd0,  32'h0F0F_0F0F, 16'd77,  1'b1, 24'h480001};

    iReset     = 1'b0;
    iOpcode    = '0;
    iTargetID  = '0;
    iSourceID  = '0;
    iAddress   = '0;
    iLength    = '0;
    iCMDValid  = 1'b0;
    iReadyBusy = 2'b11;
    iExecReady = 1'b0;
    iExecDone  = 1'b0;
    iExecError = 1'b0;

    // Reset values.
    repeat (3) tick();
    check("rst_status_valid", 64'(oStatusValid), 64'd0);
    check("rst_exec_valid", 64'(oExecValid), 64'd0);
    iReset = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", 64'(oCMDReady), 64'd1);
    check("rst_status", 64'(oStatus), 64'd0);
    check("rst_exec_fields", 64'({oExecOpcode, oExecTargetID, oExecAddress, oExecLength}), 64'd0);

    // Basic operation and issue latency.
    ready_mode = 1; err_mode = 0; lat_rand = 1'b0; exec_lat = 9;
    push_cmd(6'h05, 5'd0, 32'h1234, 16'd512);
    check("basic_exec_valid_k", 64'(oExecValid), 64'd0);
    tick();
    check("basic_exec_valid_k1", 64'(oExecValid), 64'd0);
    tick();
    check("basic_exec_valid_k2", 64'(oExecValid), 64'd1);
    check("basic_exec_fields", 64'({oExecOpcode, oExecTargetID, oExecAddress, oExecLength}),
          64'({6'h05, 5'd0, 32'h1234, 16'd512}));
    drain(60, "basic_drain");
    check("basic_status", 64'(oStatus), 64'h140000);
    check("basic_strobe_low", 64'(oStatusValid), 64'd0);
    repeat (3) tick();
    check("basic_status_hold", 64'(oStatus), 64'h140000);

    // Directed table.
    exec_lat = 2;
    for (int i = 0; i < 6; i++) begin
      err_mode = vecs[i].err ? 1 : 0;
      push_cmd(vecs[i].op, vecs[i].tgt, vecs[i].addr, vecs[i].len);
      drain(60, "vec_drain");
      check($sformatf("vec%0d_status", i), 64'(oStatus), 64'(vecs[i].exp));
    end
    err_mode = 0;

    // Stray completion pulse while idle.
    sc = strobe_cnt;
    stray_cnt++;
    repeat (6) tick();
    check("stray_no_strobe", 64'(strobe_cnt - sc), 64'd0);

    // Bad target: reported one cycle after the push, never issued.
    push_cmd(6'h01, 5'd3, 32'h42, 16'd1);
    pc = push_cyc;
    ev = exec_valid_cnt;
    drain(20, "badtgt_drain");
    check("badtgt_latency", 64'(last_strobe_cyc - pc), 64'd1);
    check("badtgt_no_exec", 64'(exec_valid_cnt - ev), 64'd0);
    check("badtgt_status", 64'(oStatus), 64'h046002);

    // Full FIFO: executor stalls, fifth command is held off.
    ready_mode = 0; exec_lat = 3;
    for (int i = 0; i < 4; i++) begin
      push_cmd(6'(6'h10 + i), 5'(i % 2), 32'hA000 + 32'(i), 16'(i));
    end
    check("full_ready_low", 64'(oCMDReady), 64'd0);
    iOpcode = 6'h14; iTargetID = 5'd0; iAddress = 32'hA004; iLength = 16'd4; iCMDValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("full_held", 64'(oCMDReady), 64'd0);
    end
    ready_mode = 1;
    push_cmd(6'h14, 5'd0, 32'hA004, 16'd4);
    drain(200, "full_drain");
    check("full_last_status", 64'(oStatus), 64'h500000);

    // R/B timeout on way 1, then a normal command on way 0.
    iReadyBusy = 2'b01;
    repeat (4) tick();
    push_cmd(6'h07, 5'd1, 32'hBEEF, 16'd8);
    pc = push_cyc;
    drain(100, "timeout_drain");
    check("timeout_latency", 64'(last_strobe_cyc - pc), 64'd21);
    check("timeout_status", 64'(oStatus), 64'h1C2003);
    push_cmd(6'h08, 5'd0, 32'hCAFE, 16'd16);
    drain(60, "after_timeout_drain");
    check("after_timeout_status", 64'(oStatus), 64'h200000);
    iReadyBusy = 2'b11;
    repeat (4) tick();

    // Randomized traffic against the model.
    ready_mode = 2; err_mode = 2; lat_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_cmd(6'($urandom), 5'($urandom_range(0, 3)), $urandom, 16'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain(2000, "random_drain");

    // Reset while busy with commands queued.
    ready_mode = 1; err_mode = 0; lat_rand = 1'b0; exec_lat = 60;
    for (int i = 0; i < 3; i++) begin
      push_cmd(6'(6'h20 + i), 5'd0, 32'h100 + 32'(i), 16'd32);
    end
    repeat (4) tick();
    sc = strobe_cnt;
    iReset = 1'b0;
    #1;
    check("midrst_status_valid", 64'(oStatusValid), 64'd0);
    check("midrst_status", 64'(oStatus), 64'd0);
    check("midrst_exec_valid", 64'(oExecValid), 64'd0);
    check("midrst_exec_fields", 64'({oExecOpcode, oExecTargetID, oExecAddress, oExecLength}),
          64'd0);
    repeat (2) tick();
    iReset = 1'b1;
    tick();
    check("midrst_cmd_ready", 64'(oCMDReady), 64'd1);
    repeat (10) tick();
    check("midrst_no_strobe", 64'(strobe_cnt - sc), 64'd0);

    // Recovery after reset.
    repeat (2) tick();
    exec_lat = 1; err_mode = 1;
    push_cmd(6'h3F, 5'd1, 32'h1, 16'd2);
    drain(60, "recover_drain");
    check("recover_status", 64'(oStatus), 64'hFC2001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nfc_command_receiver.md
# nfc_command_receiver

Command-side responder for the NAND flash controller's command bus. It accepts opcode/target/address/length commands with a valid/ready handshake and buffers them in a small FIFO. Each command waits for the target way's ready/busy line, is handed to the way executor, and is reported back as a 24-bit status word with a one-cycle valid strobe. It sits between the register-side command adapter and the per-way execution engines.

## Interface
- NumberOfWays, 2, number of NAND ways (1–32)
- FifoDepth, 4, command FIFO entries (power of two, ≥2)
- TimeoutCycles, 65535, max cycles waiting for way ready; 0 disables timeout (16-bit)

- iSystemClock  in  1  system clock
- iReset  in  1  reset, asynchronous, active-low
- iOpcode  in  6  command opcode
- iTargetID  in  5  target way index
- iSourceID  in  5  requester ID (ignored, not stored)
- iAddress  in  32  flash address
- iLength  in  16  transfer length
- iCMDValid  in  1  command valid
- oCMDReady  out  1  FIFO can accept a command
- oStatus  out  24  completion status word
- oStatusValid  out  1  one-cycle status strobe
- iReadyBusy  in  NumberOfWays  per-way R/B pin; 1 = ready; asynchronous
- oExecOpcode  out  6  opcode to executor
- oExecTargetID  out  5  way to executor
- oExecAddress  out  32  address to executor
- oExecLength  out  16  length to executor
- oExecValid  out  1  executor request valid
- iExecReady  in  1  executor accepts request
- iExecDone  in  1  executor completion pulse
- iExecError  in  1  error flag, sampled with iExecDone

## Operation
- Push on iCMDValid && oCMDReady at a rising edge; oCMDReady = (count != FifoDepth), driven from registered count.
- Pop only at REPORT exit. No simultaneous push/pop conflict: a push while full is impossible; a push and pop in the same cycle leave count unchanged.
- iReadyBusy passes through a 2-flop synchronizer, reset to all 0.
- FSM states: IDLE, WAIT_RB, ISSUE, BUSY, REPORT.
  - IDLE: if FIFO non-empty and head target ≥ NumberOfWays → REPORT with code 0x02. If non-empty and valid → WAIT_RB with timeout counter cleared.
  - WAIT_RB: synced R/B[target]=1 → ISSUE. Else counter++. If TimeoutCycles≠0 and counter reaches TimeoutCycles-1 while still busy → REPORT with code 0x03.
  - ISSUE: oExecValid=1, oExec* = FIFO head; on iExecReady → BUSY.
  - BUSY: on iExecDone → REPORT; code = iExecError ? 0x01 : 0x00.
  - REPORT: oStatusValid=1 for exactly one cycle, pop, → IDLE.
- Status word: [23:18] opcode, [17:13] target, [12:8] 0, [7:0] code (0x00 ok, 0x01 exec error, 0x02 bad target, 0x03 R/B timeout).
- iExecDone outside BUSY is ignored.

## Timing
- Reset values: oCMDReady=1 (after reset release), oStatus=0, oStatusValid=0, oExecValid=0, oExec*=0, FIFO empty, state IDLE, counter 0.
- Reset mid-operation: FIFO flushed, pending command dropped, no status emitted.
- Empty FIFO, command pushed at edge k, way ready and stable: IDLE→WAIT_RB at k+1, →ISSUE at k+2, oExecValid high after k+2.
- Synchronizer adds 2 cycles latency to R/B changes.
- oExecValid holds with stable oExec* until iExecReady. A same-cycle iExecReady is accepted on that edge.
- oStatus holds its last value between strobes.
- Commands are processed strictly in order, one in flight.

## Structure
- Shared package: status code constants (OK, EXEC_ERR, BAD_TARGET, RB_TIMEOUT), FSM state encoding, status field positions.
- Sub-module: nfc_cmd_fifo (synchronous FIFO, 59-bit entries {opcode,target,address,length}, count output). The FSM, synchronizer and timeout counter stay in the top module.

## Test plan
- Reset: hold iReset=0 mid-BUSY with 3 commands queued → all outputs at reset values, oCMDReady=1 after release, no oStatusValid.
- Basic op: way 0 ready, push {op=0x05,tgt=0,addr=0x1234,len=512}; executor ready immediately, done after 10 cycles with iExecError=0 → oStatus=0x140000 (op 0x05, tgt 0, code 0x00), single-cycle strobe.
- Full FIFO: hold iExecReady=0, push 5 commands with FifoDepth=4 → first leaves FIFO only at REPORT, so oCMDReady drops after 4 pushes and the 5th is held; status order matches push order.
- Bad target: NumberOfWays=2, push tgt=3 op=0x01 → oStatus code 0x02 target 3 within 2 cycles, executor never sees oExecValid.
- Timeout: TimeoutCycles=20, way 1 held busy → status code 0x03 exactly 20 cycles after entering WAIT_RB; a following command to way 0 proceeds normally.
- Exec error: iExecDone with iExecError=1 → code 0x01. A stray iExecDone in IDLE → no strobe.
